// File: rtl/dds_param_scheduler_if.sv
// Command channel into dds_param_scheduler: timestamped operand sets with valid/ready.
interface dds_param_scheduler_if;
  localparam int unsigned TS_W    = 48;
  localparam int unsigned FREQ_W  = 48;
  localparam int unsigned PHASE_W = 14;

  logic               valid;
  logic               ready;
  logic [TS_W-1:0]    ts;
  logic [FREQ_W-1:0]  freq;
  logic [PHASE_W-1:0] phase;
  logic               cont;

  modport master (output valid, ts, freq, phase, cont, input ready);
  modport slave  (input valid, ts, freq, phase, cont, output ready);
endinterface

// File: rtl/dds_param_scheduler.sv
// Timed parameter scheduler for the DDS phase MAC: queues commands and applies each operand set
// atomically at its timestamp. Build macro DDS_SCHED_LATE_DROP_EN discards late commands.
module dds_param_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned APPLY_LEAD = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [47:0]                 cur_time,
  input  logic                        flush,
  dds_param_scheduler_if.slave        s_cmd,
  output logic [47:0]                 mac_timeoffset,
  output logic [47:0]                 mac_freq,
  output logic [13:0]                 mac_phase,
  output logic [47:0]                 mac_accum,
  output logic                        param_update,
  output logic                        late_pulse,
  output logic [15:0]                 late_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned TW = 48;
  localparam int unsigned PW = 14;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] CALC_LAST = CW'(TW - 1);
`ifdef DDS_SCHED_LATE_DROP_EN
  localparam bit LATE_DROP = 1'b1;
`else
  localparam bit LATE_DROP = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0] ts;
    logic [TW-1:0] freq;
    logic [PW-1:0] phase;
    logic          cont;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ARMED} state_t;

  state_t        state_q, state_d;
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          work_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count_nxt_c;
  logic          ready_q;
  logic [TW-1:0] mcand_q, mplier_q, prod_q;
  logic [TW-1:0] dist_c;
  logic [CW-1:0] step_q;
  logic          push_c, pop_c, apply_c, late_c;

  assign s_cmd.ready = ready_q;
  assign push_c      = s_cmd.valid && ready_q && !flush;
  // Signed distance to the apply edge; bit 47 clear means the slot has arrived or passed.
  assign dist_c      = cur_time + TW'(APPLY_LEAD) - work_q.ts;

  always_comb begin
    count_nxt_c = fifo_level;
    if (flush) begin
      count_nxt_c = '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   count_nxt_c = fifo_level + LW'(1);
        2'b01:   count_nxt_c = fifo_level - LW'(1);
        default: count_nxt_c = fifo_level;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    apply_c = 1'b0;
    late_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_level != '0) begin
          pop_c   = 1'b1;
          state_d = mem[rd_ptr].cont ? S_CALC : S_ARMED;
        end
      end
      S_CALC: begin
        if (step_q == CALC_LAST) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (dist_c == '0) begin
          apply_c = 1'b1;
          state_d = S_IDLE;
        end else if (!dist_c[TW-1]) begin
          late_c  = 1'b1;
          apply_c = !LATE_DROP;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      pop_c   = 1'b0;
      apply_c = 1'b0;
      late_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {s_cmd.ts, s_cmd.freq, s_cmd.phase, s_cmd.cont};
  end

  // Queue bookkeeping, serial shift-add multiplier and the atomic MAC operand update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      ready_q        <= 1'b0;
      work_q         <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      prod_q         <= '0;
      step_q         <= '0;
      mac_timeoffset <= '0;
      mac_freq       <= '0;
      mac_phase      <= '0;
      mac_accum      <= '0;
      param_update   <= 1'b0;
      late_pulse     <= 1'b0;
      late_count     <= '0;
    end else begin
      fifo_level   <= count_nxt_c;
      ready_q      <= (count_nxt_c != LW'(FIFO_DEPTH));
      param_update <= apply_c;
      late_pulse   <= late_c;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (pop_c) begin
        work_q   <= mem[rd_ptr];
        mcand_q  <= mac_freq;
        mplier_q <= mem[rd_ptr].ts - mac_timeoffset;
        prod_q   <= '0;
        step_q   <= '0;
      end else if (state_q == S_CALC) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        step_q   <= step_q + CW'(1);
      end
      if (apply_c) begin
        mac_timeoffset <= work_q.ts;
        mac_freq       <= work_q.freq;
        mac_phase      <= work_q.phase;
        mac_accum      <= work_q.cont ? (mac_accum + prod_q) : '0;
      end
      if (late_c && (late_count != 16'hFFFF)) late_count <= late_count + 16'd1;
    end
  end
endmodule
